reorder_buffer: RTL

Circular in-order reorder buffer that sits between the dispatcher, the execution result bus (CDB), and the register file. It allocates one entry per dispatched instruction and captures results and resolved next-PCs from the CDB. It retires the head entry in order by driving the register-file commit port (`RoBRF_*`). On a mispredicted branch it drives the flush/redirect that clears all speculative state.

---
 rtl/reorder_buffer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at tail, CDB writeback, in-order commit, mispredict flush.
// Optional performance counters are enabled with `define ROB_PERF_COUNTER_EN.
module reorder_buffer #(
  parameter int RoB_WIDTH    = 8,
  parameter int REG_WIDTH    = 5,
  parameter int EX_REG_WIDTH = 6,
  parameter logic [EX_REG_WIDTH-1:0] NON_REG = 6'b100000
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst,
  input  logic                    Sys_rdy,
  input  logic                    DPRoB_en,
  input  logic [EX_REG_WIDTH-1:0] DPRoB_rd,
  input  logic                    DPRoB_is_branch,
  input  logic [31:0]             DPRoB_pred_pc,
  output logic                    RoBDP_full,
  output logic [RoB_WIDTH-1:0]    RoBDP_tail_index,
  input  logic [RoB_WIDTH-1:0]    DPRoB_Qj_index,
  input  logic [RoB_WIDTH-1:0]    DPRoB_Qk_index,
  output logic                    RoBDP_Qj_ready,
  output logic                    RoBDP_Qk_ready,
  output logic [31:0]             RoBDP_Qj_value,
  output logic [31:0]             RoBDP_Qk_value,
  input  logic                    CDBRoB_en,
  input  logic [RoB_WIDTH-1:0]    CDBRoB_index,
  input  logic [31:0]             CDBRoB_value,
  input  logic [31:0]             CDBRoB_next_pc,
  output logic                    RoBRF_en,
  output logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
  output logic [REG_WIDTH-1:0]    RoBRF_rd,
  output logic [31:0]             RoBRF_value,
  output logic                    RoBRF_pre_judge,
  output logic                    RoB_flush,
  output logic [31:0]             RoBIF_new_pc
`ifdef ROB_PERF_COUNTER_EN
  ,
  output logic [31:0]             RoB_commit_cnt,
  output logic [31:0]             RoB_mispredict_cnt
`endif
);

  localparam int RoB_SIZE = 1 << RoB_WIDTH;
  localparam logic [RoB_WIDTH:0] FULL_CNT = (RoB_WIDTH+1)'(RoB_SIZE);

  logic [RoB_SIZE-1:0]     busy;
  logic [RoB_SIZE-1:0]     ready;
  logic [RoB_SIZE-1:0]     is_branch_q;
  logic [EX_REG_WIDTH-1:0] rd_q      [RoB_SIZE];
  logic [31:0]             pred_pc_q [RoB_SIZE];
  logic [31:0]             value_q   [RoB_SIZE];
  logic [31:0]             next_pc_q [RoB_SIZE];

  logic [RoB_WIDTH-1:0] head;
  logic [RoB_WIDTH-1:0] tail;
  logic [RoB_WIDTH:0]   count;

  logic do_alloc;
  logic do_commit;
  logic mispredict;
  logic cdb_hit;
  logic qj_cdb;
  logic qk_cdb;

  assign RoBDP_full       = (count == FULL_CNT);
  assign RoBDP_tail_index = tail;

  always_comb begin
    do_alloc   = DPRoB_en && !RoBDP_full && !RoB_flush;
    do_commit  = busy[head] && ready[head];
    mispredict = do_commit && is_branch_q[head] && (next_pc_q[head] != pred_pc_q[head]);
    cdb_hit    = CDBRoB_en && busy[CDBRoB_index];
  end

  // Operand forward: a same-cycle CDB result wins over the stored value.
  always_comb begin
    qj_cdb = CDBRoB_en && (CDBRoB_index == DPRoB_Qj_index);
    qk_cdb = CDBRoB_en && (CDBRoB_index == DPRoB_Qk_index);
    RoBDP_Qj_ready = ready[DPRoB_Qj_index] || qj_cdb;
    RoBDP_Qk_ready = ready[DPRoB_Qk_index] || qk_cdb;
    RoBDP_Qj_value = '0;
    RoBDP_Qk_value = '0;
    if (qj_cdb)
      RoBDP_Qj_value = CDBRoB_value;
    else if (ready[DPRoB_Qj_index])
      RoBDP_Qj_value = value_q[DPRoB_Qj_index];
    if (qk_cdb)
      RoBDP_Qk_value = CDBRoB_value;
    else if (ready[DPRoB_Qk_index])
      RoBDP_Qk_value = value_q[DPRoB_Qk_index];
  end

  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      busy            <= '0;
      ready           <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      RoBRF_en        <= 1'b0;
      RoBRF_RoB_index <= '0;
      RoBRF_rd        <= '0;
      RoBRF_value     <= '0;
      RoBRF_pre_judge <= 1'b1;
      RoB_flush       <= 1'b0;
      RoBIF_new_pc    <= '0;
    end else if (Sys_rdy) begin
      RoBRF_en        <= do_commit;
      RoB_flush       <= mispredict;
      RoBRF_pre_judge <= !mispredict;
      if (do_commit) begin
        RoBRF_RoB_index <= head;
        if (rd_q[head] == NON_REG) begin
          RoBRF_rd    <= '0;
          RoBRF_value <= '0;
        end else begin
          RoBRF_rd    <= rd_q[head][REG_WIDTH-1:0];
          RoBRF_value <= value_q[head];
        end
      end
      if (mispredict) begin
        // Wrong path: drop every entry, including anything arriving this edge.
        RoBIF_new_pc <= next_pc_q[head];
        busy         <= '0;
        ready        <= '0;
        head         <= '0;
        tail         <= '0;
        count        <= '0;
      end else begin
        if (cdb_hit)
          ready[CDBRoB_index] <= 1'b1;
        if (do_alloc) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + 1'b1;
        end
        if (do_commit) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + 1'b1;
        end
        count <= count + (RoB_WIDTH+1)'(do_alloc) - (RoB_WIDTH+1)'(do_commit);
      end
    end
  end

  // Payload needs no reset: it is only observed through busy/ready, which are reset.
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst && Sys_rdy && !mispredict) begin
      if (cdb_hit) begin
        value_q[CDBRoB_index]   <= CDBRoB_value;
        next_pc_q[CDBRoB_index] <= CDBRoB_next_pc;
      end
      if (do_alloc) begin
        rd_q[tail]        <= DPRoB_rd;
        is_branch_q[tail] <= DPRoB_is_branch;
        pred_pc_q[tail]   <= DPRoB_pred_pc;
      end
    end
  end

`ifdef ROB_PERF_COUNTER_EN
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      RoB_commit_cnt     <= '0;
      RoB_mispredict_cnt <= '0;
    end else if (Sys_rdy) begin
      if (do_commit)
        RoB_commit_cnt <= RoB_commit_cnt + 32'd1;
      if (mispredict)
        RoB_mispredict_cnt <= RoB_mispredict_cnt + 32'd1;
    end
  end
`endif

endmodule
